// File: rtl/regfile_param.sv
// Parametrised integer register file: two combinational read ports, one write port,
// x0 hardwired to zero, post-reset clear sweep. Define REGFILE_BYPASS_EN for write-to-read forwarding.
module regfile_param #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic [XLEN-1:0] rd_data1,
  output logic [XLEN-1:0] rd_data2,
  input  logic            wrEn,
  input  logic [AW-1:0]   ws,
  input  logic [XLEN-1:0] wr_data,
  output logic            busy
);

  // Storage address width: just enough bits to reach NREGS-1.
  localparam int IW = (NREGS > 2) ? $clog2(NREGS) : 1;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     ptr_q, ptr_d;

  logic              mem_we;
  logic [IW-1:0]     mem_waddr;
  logic [XLEN-1:0]   mem_wdata;
  logic              wr_ok;

  logic [XLEN-1:0]   mem [1:NREGS-1];

  function automatic logic in_range(input logic [AW-1:0] idx);
    return (32'(idx) < NREGS);
  endfunction

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    state_d   = state_q;
    ptr_d     = ptr_q;
    mem_we    = 1'b0;
    mem_waddr = ws[IW-1:0];
    mem_wdata = wr_data;
    wr_ok     = wrEn && (ws != '0) && in_range(ws);
    busy      = (state_q == CLEAR);

    case (state_q)
      CLEAR: begin
        // Gate with reset so a clock running during reset never touches the array.
        mem_we    = reset;
        mem_waddr = ptr_q[IW-1:0];
        mem_wdata = '0;
        if (ptr_q == AW'(NREGS - 1)) begin
          state_d = READY;
        end else begin
          ptr_d = ptr_q + AW'(1);
        end
      end
      READY: begin
        mem_we = wr_ok;
      end
      default: begin
        state_d = CLEAR;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments; combinational logic uses blocking.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= CLEAR;
      ptr_q   <= AW'(1);
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // NOTE: the array has no reset; the clear sweep is what zeroes it, keeping it RAM-friendly.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  always_comb begin
    rd_data1 = '0;
    rd_data2 = '0;
    if (!busy) begin
      if ((rs1 != '0) && in_range(rs1)) rd_data1 = mem[rs1[IW-1:0]];
      if ((rs2 != '0) && in_range(rs2)) rd_data2 = mem[rs2[IW-1:0]];
`ifdef REGFILE_BYPASS_EN
      // wr_ok already excludes x0 and out-of-range indices.
      if (wr_ok && (rs1 == ws)) rd_data1 = wr_data;
      if (wr_ok && (rs2 == ws)) rd_data2 = wr_data;
`endif
    end
  end

endmodule

// File: tb/tb_regfile_param.sv
// Scoreboard bench for regfile_param: default (32 regs) and 16-register instances share stimulus,
// each checked against an array-based reference model.
module tb_regfile_param;

  logic        clk;
  logic        reset;
  logic [4:0]  rs1, rs2, ws;
  logic        wrEn;
  logic [31:0] wr_data;
  logic [31:0] rd1_a, rd2_a, rd1_b, rd2_b;
  logic        busy_a, busy_b;

  regfile_param dut_a (
    .clk(clk), .reset(reset), .rs1(rs1), .rs2(rs2),
    .rd_data1(rd1_a), .rd_data2(rd2_a),
    .wrEn(wrEn), .ws(ws), .wr_data(wr_data), .busy(busy_a)
  );

  regfile_param #(.XLEN(32), .NREGS(16), .AW(5)) dut_b (
    .clk(clk), .reset(reset), .rs1(rs1), .rs2(rs2),
    .rd_data1(rd1_b), .rd_data2(rd2_b),
    .wrEn(wrEn), .ws(ws), .wr_data(wr_data), .busy(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] r1a, r2a, r1b, r2b;
    logic        ba, bb;
    int          ph;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   phase    = 0;

  // Reference model: index 0 = 32-register instance, index 1 = 16-register instance.
  logic [31:0] mdl [2][32];
  logic        mbusy [2];
  int          mcnt  [2];
  int          nr    [2] = '{32, 16};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req, input int ph);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s phase=%0d got=%h expected=%h at t=%0t", name, ph, act, req, $time);
    end
  endtask

  function automatic logic [31:0] model_rd(input int k, input logic [4:0] idx, input logic we,
                                           input logic [4:0] wi, input logic [31:0] wd);
    if (mbusy[k]) return 32'h0;
    if (idx == 5'd0 || int'(idx) >= nr[k]) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (we && wi == idx) return wd;
`else
    if (we && wi == idx && wd === 32'hx) return 32'h0;
`endif
    return mdl[k][idx];
  endfunction

  // One clock cycle: drive inputs, queue the mid-cycle expectation, advance the model at the edge.
  task automatic step(input logic rst_i, input logic we, input logic [4:0] wi, input logic [31:0] wd,
                      input logic [4:0] r1, input logic [4:0] r2);
    exp_t e;
    reset   = rst_i;
    wrEn    = we;
    ws      = wi;
    wr_data = wd;
    rs1     = r1;
    rs2     = r2;
    if (!rst_i) begin
      for (int k = 0; k < 2; k++) begin
        mbusy[k] = 1'b1;
        mcnt[k]  = 0;
      end
    end
    e.r1a = model_rd(0, r1, we, wi, wd);
    e.r2a = model_rd(0, r2, we, wi, wd);
    e.ba  = mbusy[0];
    e.r1b = model_rd(1, r1, we, wi, wd);
    e.r2b = model_rd(1, r2, we, wi, wd);
    e.bb  = mbusy[1];
    e.ph  = phase;
    exp_q.push_back(e);
    @(posedge clk);
    if (rst_i) begin
      for (int k = 0; k < 2; k++) begin
        if (mbusy[k]) begin
          mcnt[k]++;
          if (mcnt[k] == nr[k] - 1) begin
            for (int j = 0; j < 32; j++) mdl[k][j] = 32'h0;
            mbusy[k] = 1'b0;
          end
        end else if (we && wi != 5'd0 && int'(wi) < nr[k]) begin
          mdl[k][wi] = wd;
        end
      end
    end
    #1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("busy_n32",     {31'b0, busy_a}, {31'b0, e.ba}, e.ph);
      check("rd_data1_n32", rd1_a, e.r1a, e.ph);
      check("rd_data2_n32", rd2_a, e.r2a, e.ph);
      check("busy_n16",     {31'b0, busy_b}, {31'b0, e.bb}, e.ph);
      check("rd_data1_n16", rd1_b, e.r1b, e.ph);
      check("rd_data2_n16", rd2_b, e.r2b, e.ph);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic read_sweep();
    for (int i = 0; i < 32; i++) step(1'b1, 1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      mbusy[k] = 1'b1;
      mcnt[k]  = 0;
      for (int j = 0; j < 32; j++) mdl[k][j] = 32'h0;
    end
    reset = 1'b1; wrEn = 1'b0; ws = '0; wr_data = '0; rs1 = '0; rs2 = '0;
    #2 reset = 1'b0;
    @(posedge clk); #1;

    // Reset hold, then sweep with a write to reg 3 held through the transition edge.
    phase = 1;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 5'd0, 32'h0, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
    for (int i = 0; i < 31; i++) step(1'b1, 1'b1, 5'd3, 32'h55, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
    read_sweep();

    // Write then read.
    phase = 2;
    step(1'b1, 1'b1, 5'd5,  32'hDEADBEEF, 5'd5, 5'd31);
    step(1'b1, 1'b1, 5'd31, 32'h1,        5'd5, 5'd31);
    step(1'b1, 1'b0, 5'd0,  32'h0,        5'd5, 5'd31);

    // x0 protection.
    phase = 3;
    step(1'b1, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
    read_sweep();

    // Mid-sweep reset.
    phase = 4;
    step(1'b1, 1'b1, 5'd7, 32'h7, 5'd7, 5'd0);
    step(1'b0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd7);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 5'd0, 32'h0, 5'd7, 5'd1);
    step(1'b0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd7);
    step(1'b0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd7);
    for (int i = 0; i < 34; i++) step(1'b1, 1'b0, 5'd0, 32'h0, 5'd7, 5'd31);

    // Same-cycle write/read of one register (bypass or old value).
    phase = 5;
    step(1'b1, 1'b1, 5'd9, 32'h10, 5'd0, 5'd0);
    step(1'b1, 1'b1, 5'd9, 32'h20, 5'd9, 5'd9);
    step(1'b1, 1'b0, 5'd0, 32'h0,  5'd9, 5'd9);

    // Index beyond NREGS on the 16-register instance.
    phase = 6;
    step(1'b1, 1'b1, 5'd20, 32'hABCD1234, 5'd20, 5'd15);
    step(1'b1, 1'b0, 5'd0,  32'h0,        5'd20, 5'd15);

    // Randomised traffic with occasional resets.
    phase = 7;
    for (int i = 0; i < 400; i++) begin
      logic       rst_r;
      logic [4:0] wi, r1, r2;
      rst_r = ($urandom_range(0, 99) != 0);
      wi    = 5'($urandom_range(0, 31));
      r1    = ($urandom_range(0, 3) == 0) ? wi : 5'($urandom_range(0, 31));
      r2    = 5'($urandom_range(0, 31));
      step(rst_r, 1'($urandom_range(0, 1)), wi, $urandom, r1, r2);
    end

    @(negedge clk); #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain got=%0d expected=0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
